// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage; waits for data_ok, aligns load data, absorbs flushed responses
module mem_stage (
   input  logic         clk,
   input  logic         reset,
   input  logic         es_to_ms_valid,
   input  logic [165:0] es_to_ms_bus,
   output logic         ms_allowin,
   input  logic         ws_allowin,
   output logic         ms_to_ws_valid,
   output logic [154:0] ms_to_ws_bus,
   output logic [42:0]  ms_res,
   output logic [6:0]   memexc,
   input  logic         wbexc,
   input  logic [31:0]  data_sram_rdata,
   input  logic         data_sram_dataok
);
   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2} state_t;
   state_t       r_state;
   state_t       w_state_nxt;
   logic [165:0] r_bus;
   logic [31:0]  r_data_buf;
   logic         r_buf_valid;
   logic [1:0]   r_discard;
   logic         w_ms_valid;
   logic         w_resp_ok;
   logic         w_ready_go;
   logic         w_accept;
   logic         w_handoff;
   logic         w_es_owes;
   logic         w_disc_inc;
   logic         w_disc_dec;
   logic [6:0]   w_exc;
   logic [1:0]   w_k;
   logic [6:0]   w_op;
   logic         w_rfm;
   logic [31:0]  w_raw;
   logic [31:0]  w_shr;
   logic [31:0]  w_shl;
   logic [15:0]  w_half;
   logic [31:0]  w_load;
   logic [31:0]  w_final;
   logic [3:0]   w_gwe;
   logic         w_unused;
   assign w_exc      = r_bus[121:115];
   assign w_k        = r_bus[114:113];
   assign w_op       = r_bus[112:106];
   assign w_rfm      = r_bus[73];
   assign w_unused   = ^{r_bus[165], w_op[0]};
   assign w_es_owes  = (es_to_ms_bus[121:115] == 7'd0) && (es_to_ms_bus[73] || es_to_ms_bus[165]);
   assign w_ms_valid = r_state != S_EMPTY;
   assign w_resp_ok  = data_sram_dataok && (r_discard == 2'd0);
   assign w_ready_go = (r_state == S_READY) || ((r_state == S_WAIT) && w_resp_ok);
   assign ms_allowin = !w_ms_valid || (w_ready_go && ws_allowin);
   assign ms_to_ws_valid = w_ms_valid && w_ready_go && !wbexc;
   assign w_accept   = es_to_ms_valid && ms_allowin;
   assign w_handoff  = ms_to_ws_valid && ws_allowin;
   assign w_disc_inc = wbexc && (r_state == S_WAIT) && !w_resp_ok;
   assign w_disc_dec = data_sram_dataok && (r_discard != 2'd0);
   // next pipeline state: flush wins, then a new entry, then handoff, then response arrival
   always_comb begin
      w_state_nxt = r_state;
      if (wbexc)
         w_state_nxt = S_EMPTY;
      else if (w_accept)
         w_state_nxt = w_es_owes ? S_WAIT : S_READY;
      else if (w_handoff)
         w_state_nxt = S_EMPTY;
      else if ((r_state == S_WAIT) && w_resp_ok)
         w_state_nxt = S_READY;
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_EMPTY;
      else
         r_state <= w_state_nxt;
   end
   // instruction bus register, loaded only on acceptance
   always_ff @(posedge clk) begin
      if (reset)
         r_bus <= '0;
      else if (w_accept)
         r_bus <= es_to_ms_bus;
   end
   // hold a response that arrived while write-back was stalled
   always_ff @(posedge clk) begin
      if (reset || wbexc || w_handoff) begin
         r_buf_valid <= 1'b0;
         r_data_buf  <= '0;
      end else if ((r_state == S_WAIT) && w_resp_ok && !ws_allowin) begin
         r_buf_valid <= 1'b1;
         r_data_buf  <= data_sram_rdata;
      end
   end
   // count responses still owed by flushed accesses; saturates at 3
   always_ff @(posedge clk) begin
      if (reset)
         r_discard <= 2'd0;
      else if (w_disc_inc && !w_disc_dec && (r_discard != 2'd3))
         r_discard <= r_discard + 2'd1;
      else if (w_disc_dec && !w_disc_inc)
         r_discard <= r_discard - 2'd1;
   end
   // load alignment and extension; 3-k equals ~k for a 2-bit k
   always_comb begin
      w_raw   = r_buf_valid ? r_data_buf : data_sram_rdata;
      w_shr   = w_raw >> {w_k, 3'b000};
      w_shl   = w_raw << {~w_k, 3'b000};
      w_half  = w_k[1] ? w_raw[31:16] : w_raw[15:0];
      w_load  = w_op[1] ? {{24{w_shr[7]}}, w_shr[7:0]} :
                w_op[2] ? {24'd0, w_shr[7:0]} :
                w_op[3] ? {{16{w_half[15]}}, w_half} :
                w_op[4] ? {16'd0, w_half} :
                w_op[5] ? w_shl :
                w_op[6] ? w_shr : w_raw;
      w_final = w_rfm ? w_load : r_bus[63:32];
      w_gwe   = (w_exc != 7'd0) ? 4'd0 :
                (w_rfm && w_op[5]) ? 4'hf << ~w_k :
                (w_rfm && w_op[6]) ? 4'hf >> w_k : r_bus[72:69];
   end
   assign ms_to_ws_bus = {r_bus[164], r_bus[163:122], w_exc, r_bus[105:74], w_gwe, r_bus[68:64], w_final, r_bus[31:0]};
   assign ms_res       = {w_ms_valid && r_bus[163], r_state == S_WAIT, w_ms_valid ? w_gwe : 4'd0, r_bus[68:64], w_final};
   assign memexc       = w_ms_valid ? w_exc : 7'd0;
endmodule
